ber_accum: RTL



---
 rtl/ber_accum_pkg.sv | 5 +
 rtl/ber_accum_sat_accum.sv | 20 ++
 rtl/ber_accum.sv | 71 +++++++
 3 files changed

// File: rtl/ber_accum_pkg.sv
// ber_accum_pkg: state encodings and frame width shared by the comparator and BER accumulator.
package ber_accum_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam int FRAME_W = 12;
endpackage

// File: rtl/ber_accum_sat_accum.sv
// sat_accum: saturating accumulator with synchronous clear and enable.
module sat_accum #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] add,
  output logic [W-1:0] sum,
  output logic [W-1:0] nxt
);
  logic [W:0] raw;
  assign raw = {1'b0, sum} + {1'b0, add};
  assign nxt = raw[W] ? '1 : raw[W-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (clr) sum <= '0;
    else if (en) sum <= nxt;
endmodule

// File: rtl/ber_accum.sv
// ber_accum: per-run bit/frame error accumulator for BER readout; BER_EARLY_STOP_EN enables the error-threshold stop.
module ber_accum
  import ber_accum_pkg::*;
#(
  parameter int NUM_FRAMES = 1000,
  parameter int CNT_W      = 24,
  parameter int DIS_W      = 4,
  parameter int MAX_DIS    = FRAME_W,
  parameter int MAX_ERR    = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dis_valid,
  input  logic [DIS_W-1:0] ham_dis,
  output logic             dis_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] frm_cnt,
  output logic [CNT_W-1:0] frm_err_cnt,
  output logic             range_err,
  output logic             early_stop
);
`ifdef BER_EARLY_STOP_EN
  localparam bit ES_EN = 1'b1;
`else
  localparam bit ES_EN = 1'b0;
`endif
  state_t state, state_n;
  logic accept, clr, last, hit_err;
  logic [CNT_W-1:0] err_nxt, frm_nxt, unused_fe_nxt;
  assign accept = state == ST_RUN && dis_valid;
  assign clr = start && state != ST_RUN;
  assign last = 32'(frm_nxt) == NUM_FRAMES;
  assign hit_err = ES_EN && 32'(err_nxt) >= MAX_ERR;
  assign dis_ready = busy;
  always_comb begin
    state_n = state;
    state_n = clr ? ST_RUN : (accept && (last || hit_err)) ? ST_DONE : state;
  end
  // Status flags are registered from the next state so they line up with the counters.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      range_err  <= 1'b0;
      early_stop <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= state_n == ST_RUN;
      done  <= state_n == ST_DONE;
      if (clr) range_err <= 1'b0;
      else if (accept && ham_dis > DIS_W'(MAX_DIS)) range_err <= 1'b1;
      if (clr) early_stop <= 1'b0;
      else if (accept && hit_err) early_stop <= 1'b1;
    end
  sat_accum #(.W(CNT_W)) u_err (
    .clk(clk), .rst(rst), .clr(clr), .en(accept),
    .add(CNT_W'(ham_dis)), .sum(err_cnt), .nxt(err_nxt)
  );
  sat_accum #(.W(CNT_W)) u_frm (
    .clk(clk), .rst(rst), .clr(clr), .en(accept),
    .add(CNT_W'(1)), .sum(frm_cnt), .nxt(frm_nxt)
  );
  sat_accum #(.W(CNT_W)) u_fe (
    .clk(clk), .rst(rst), .clr(clr), .en(accept),
    .add(CNT_W'(ham_dis != '0)), .sum(frm_err_cnt), .nxt(unused_fe_nxt)
  );
endmodule
